// File: rtl/dc_stage.sv
// ----------------------------------------------------------------------------
// dc_stage -- data-cache access stage between EX and MEM.
//
// Registers the EX->DC bus. For each load or store it runs one transaction on
// the data bus using the req / addr_ok / data_ok handshake. While that
// transaction is outstanding it holds the front of the pipeline. Once the
// transaction completes, it presents the payload and the captured load word
// to MEM.
//
// Ports
//   i_clk               clock
//   i_rst               synchronous active-high reset
//   i_stall             pipeline stall vector from ctrl (1 = stop)
//   i_ex_to_dc_bus      {store_wdata[31:0], DC->MEM payload[150:0]}
//   o_data_req          request valid
//   o_data_wr           1 = store, 0 = load
//   o_data_size         00 byte, 01 half, 10 word
//   o_data_wstrb        byte enables (stores only)
//   o_data_addr         byte address (= ex_result)
//   o_data_wdata        store data, already lane-replicated by EX
//   i_data_addr_ok      request accepted
//   i_data_data_ok      response valid
//   i_data_rdata        response data
//   o_stallreq_for_dc   hold pipeline stages 0..3
//   o_dc_to_mem_bus     registered payload to MEM
//   o_data_sram_rdata   registered load word to MEM
//   o_dc_to_rf_bus      {is_load, hilo_bus[65:0], rf_we, rf_waddr, ex_result}
//
// Payload layout (bit positions):
//   mem_op[150:143] hilo[142:77] pc[76:45] ram_en[44] ram_wen[43]
//   ram_sel[42:39] sel_rf_res[38] rf_we[37] rf_waddr[36:32] ex_result[31:0]
// mem_op is one-hot: 0 lb, 1 lbu, 2 lh, 3 lhu, 4 lw, 5 sb, 6 sh, 7 sw.
// ----------------------------------------------------------------------------
module dc_stage #(
    parameter int unsigned EX_TO_DC_WD  = 183,
    parameter int unsigned DC_TO_MEM_WD = 151,
    parameter int unsigned STALL_WD     = 6
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [STALL_WD-1:0]     i_stall,
    input  logic [EX_TO_DC_WD-1:0]  i_ex_to_dc_bus,
    output logic                    o_data_req,
    output logic                    o_data_wr,
    output logic [1:0]              o_data_size,
    output logic [3:0]              o_data_wstrb,
    output logic [31:0]             o_data_addr,
    output logic [31:0]             o_data_wdata,
    input  logic                    i_data_addr_ok,
    input  logic                    i_data_data_ok,
    input  logic [31:0]             i_data_rdata,
    output logic                    o_stallreq_for_dc,
    output logic [DC_TO_MEM_WD-1:0] o_dc_to_mem_bus,
    output logic [31:0]             o_data_sram_rdata,
    output logic [104:0]            o_dc_to_rf_bus
);

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;
    localparam int unsigned MEM_OP_LSB = 143;

    typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

    state_e                 r_state;
    state_e                 w_state_next;
    logic [EX_TO_DC_WD-1:0] r_bus;
    logic [31:0]            r_rdata_buf;

    logic [31:0] w_ex_result;
    logic [4:0]  w_rf_waddr;
    logic        w_rf_we;
    logic        w_sel_rf_res;
    logic [3:0]  w_ram_sel;
    logic        w_ram_wen;
    logic        w_ram_en;
    logic [65:0] w_hilo;
    logic [31:0] w_store_wdata;
    logic        w_access;
    logic        w_resp;
    logic        w_unused;

    // Only stages 2 and 3 of the stall vector concern this stage.
    assign w_unused = ^{i_stall[STALL_WD-1:4], i_stall[1:0]};

    // Input register: a bubble is inserted when DC stops but MEM moves on.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bus <= '0;
        end else if (i_stall[2] == STOP && i_stall[3] == NO_STOP) begin
            r_bus <= '0;
        end else if (i_stall[2] == NO_STOP) begin
            r_bus <= i_ex_to_dc_bus;
        end
    end

    assign w_ex_result   = r_bus[31:0];
    assign w_rf_waddr    = r_bus[36:32];
    assign w_rf_we       = r_bus[37];
    assign w_sel_rf_res  = r_bus[38];
    assign w_ram_sel     = r_bus[42:39];
    assign w_ram_wen     = r_bus[43];
    assign w_ram_en      = r_bus[44];
    assign w_hilo        = r_bus[142:77];
    assign w_store_wdata = r_bus[182:151];
    assign w_access      = w_ram_en;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // w_resp marks the cycle in which the outstanding transaction's data_ok
    // lands. A data_ok that arrives with nothing outstanding is ignored.
    always_comb begin
        w_state_next = r_state;
        o_data_req   = 1'b0;
        w_resp       = 1'b0;
        unique case (r_state)
            StIdle: begin
                o_data_req = w_access;
                if (w_access) begin
                    if (i_data_addr_ok) begin
                        w_state_next = i_data_data_ok ? StDone : StData;
                        w_resp       = i_data_data_ok;
                    end else begin
                        w_state_next = StAddr;
                    end
                end
            end
            StAddr: begin
                o_data_req = 1'b1;
                if (i_data_addr_ok) begin
                    w_state_next = i_data_data_ok ? StDone : StData;
                    w_resp       = i_data_data_ok;
                end
            end
            StData: begin
                if (i_data_data_ok) begin
                    w_state_next = StDone;
                    w_resp       = 1'b1;
                end
            end
            StDone: begin
                // Leave on the same edge that MEM takes this op.
                if (i_stall[3] == NO_STOP) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata_buf <= '0;
        end else if (w_resp && !w_ram_wen) begin
            r_rdata_buf <= i_data_rdata;
        end
    end

    always_comb begin
        o_data_size = 2'b00;
        if (r_bus[MEM_OP_LSB+2] || r_bus[MEM_OP_LSB+3] || r_bus[MEM_OP_LSB+6]) begin
            o_data_size = 2'b01;
        end else if (r_bus[MEM_OP_LSB+4] || r_bus[MEM_OP_LSB+7]) begin
            o_data_size = 2'b10;
        end
    end

    // Low in StDone, so a zero-wait access costs exactly one stall cycle.
    assign o_stallreq_for_dc = ((r_state == StIdle) && w_access) ||
                               (r_state == StAddr) || (r_state == StData);

    assign o_data_wr         = w_ram_wen;
    assign o_data_wstrb      = w_ram_wen ? w_ram_sel : 4'b0000;
    assign o_data_addr       = w_ex_result;
    assign o_data_wdata      = w_store_wdata;
    assign o_dc_to_mem_bus   = r_bus[DC_TO_MEM_WD-1:0];
    assign o_data_sram_rdata = r_rdata_buf;
    assign o_dc_to_rf_bus    = {w_ram_en & ~w_ram_wen & w_sel_rf_res, w_hilo, w_rf_we,
                                w_rf_waddr, w_ex_result};

endmodule

// File: tb/tb_dc_stage.sv
// ----------------------------------------------------------------------------
// tb_dc_stage -- self-checking bench for dc_stage.
// The bench plays ctrl (stall vector), EX (input bus) and the data-bus slave.
// Expectations come from a transaction-level model: the access width is taken
// from the op, the stall length is addr-wait + 1 + data-wait, and the load
// word tracks the most recent completed load.
// ----------------------------------------------------------------------------
module tb_dc_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   ext_stall;
    logic [5:0]   stall;
    logic [182:0] ex_bus;
    logic         addr_ok;
    logic         data_ok;
    logic [31:0]  rdata;

    logic         data_req;
    logic         data_wr;
    logic [1:0]   data_size;
    logic [3:0]   data_wstrb;
    logic [31:0]  data_addr;
    logic [31:0]  data_wdata;
    logic         stallreq;
    logic [150:0] dc_to_mem_bus;
    logic [31:0]  data_sram_rdata;
    logic [104:0] dc_to_rf_bus;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_rdata;

    typedef struct {
        int          op;      // 0 lb,1 lbu,2 lh,3 lhu,4 lw,5 sb,6 sh,7 sw,8 non-memory
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  sel;
        logic [65:0] hilo;
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  waddr;
        logic        sel_rf;
        int          aw;      // cycles of req before addr_ok
        int          dw;      // cycles after addr_ok until data_ok
        int          mhold;   // cycles a later stage holds us in DONE
    } txn_t;

    always #5 clk = ~clk;

    // ctrl: a DC stall request stops stages 0..3.
    assign stall = stallreq ? 6'b001111 : ext_stall;

    dc_stage dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_stall           (stall),
        .i_ex_to_dc_bus    (ex_bus),
        .o_data_req        (data_req),
        .o_data_wr         (data_wr),
        .o_data_size       (data_size),
        .o_data_wstrb      (data_wstrb),
        .o_data_addr       (data_addr),
        .o_data_wdata      (data_wdata),
        .i_data_addr_ok    (addr_ok),
        .i_data_data_ok    (data_ok),
        .i_data_rdata      (rdata),
        .o_stallreq_for_dc (stallreq),
        .o_dc_to_mem_bus   (dc_to_mem_bus),
        .o_data_sram_rdata (data_sram_rdata),
        .o_dc_to_rf_bus    (dc_to_rf_bus)
    );

    function automatic bit is_mem(int op);
        return op >= 0 && op <= 7;
    endfunction

    function automatic bit is_store(int op);
        return op >= 5 && op <= 7;
    endfunction

    // Access width in bytes -> size code log2(bytes).
    function automatic logic [1:0] size_of(int op);
        int bytes;
        case (op)
            2, 3, 6: bytes = 2;
            4, 7:    bytes = 4;
            default: bytes = 1;
        endcase
        return 2'($clog2(bytes));
    endfunction

    function automatic logic [182:0] build(txn_t t);
        logic [7:0] mop;
        mop = is_mem(t.op) ? (8'b1 << t.op) : 8'h00;
        return {t.wdata, mop, t.hilo, t.pc, is_mem(t.op), is_store(t.op), t.sel,
                t.sel_rf, t.rf_we, t.waddr, t.addr};
    endfunction

    function automatic logic [104:0] rf_of(txn_t t);
        logic ld;
        ld = is_mem(t.op) && !is_store(t.op) && t.sel_rf;
        return {ld, t.hilo, t.rf_we, t.waddr, t.addr};
    endfunction

    function automatic txn_t mk(int op, logic [31:0] addr, logic [3:0] sel, logic [31:0] rd,
                                int aw, int dw, int mhold);
        txn_t t;
        t.op = op; t.addr = addr; t.sel = sel; t.rdata = rd;
        t.aw = aw; t.dw = dw; t.mhold = mhold;
        t.wdata  = $urandom;
        t.hilo   = {$urandom, $urandom, 2'($urandom)};
        t.pc     = $urandom;
        t.rf_we  = 1'($urandom);
        t.waddr  = 5'($urandom);
        t.sel_rf = 1'($urandom);
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issues one op and finishes at the negedge of the last DONE cycle with
    // the stall released, so the caller may queue the next op right away.
    task automatic do_op(input txn_t t, input string nm);
        logic [182:0] full;
        logic [150:0] pay;
        int nstall;
        full = build(t);
        pay  = full[150:0];
        ex_bus = full; ext_stall = '0; addr_ok = 1'b0; data_ok = 1'b0;
        tick();
        ex_bus = '0;
        checks++;
        if (dc_to_mem_bus !== pay) begin
            errors++;
            $display("FAIL %s mem_bus: got %h want %h", nm, dc_to_mem_bus, pay);
        end
        checks++;
        if (dc_to_rf_bus !== rf_of(t)) begin
            errors++;
            $display("FAIL %s rf_bus: got %h want %h", nm, dc_to_rf_bus, rf_of(t));
        end
        if (!is_mem(t.op)) begin
            checks++;
            if (data_req !== 1'b0 || stallreq !== 1'b0) begin
                errors++;
                $display("FAIL %s nop req/stall: got %b%b want 00", nm, data_req, stallreq);
            end
            return;
        end
        nstall = 0;
        for (int c = 0; c <= t.aw + t.dw; c++) begin
            checks++;
            if (data_req !== (c <= t.aw)) begin
                errors++;
                $display("FAIL %s req c%0d: got %b want %b", nm, c, data_req, c <= t.aw);
            end
            if (c <= t.aw) begin
                checks++;
                if (data_addr !== t.addr || data_wr !== is_store(t.op) ||
                    data_size !== size_of(t.op) || data_wdata !== t.wdata ||
                    data_wstrb !== (is_store(t.op) ? t.sel : 4'b0000)) begin
                    errors++;
                    $display("FAIL %s fields c%0d: got a=%h wr=%b sz=%b st=%b wd=%h want a=%h wr=%b sz=%b st=%b wd=%h",
                             nm, c, data_addr, data_wr, data_size, data_wstrb, data_wdata,
                             t.addr, is_store(t.op), size_of(t.op),
                             is_store(t.op) ? t.sel : 4'b0000, t.wdata);
                end
            end
            if (stallreq === 1'b1) nstall++;
            addr_ok = (c == t.aw);
            data_ok = (c == t.aw + t.dw);
            rdata   = data_ok ? t.rdata : $urandom;
            tick();
            addr_ok = 1'b0; data_ok = 1'b0; rdata = $urandom;
        end
        if (!is_store(t.op)) exp_rdata = t.rdata;
        checks++;
        if (nstall != t.aw + 1 + t.dw) begin
            errors++;
            $display("FAIL %s stall_len: got %0d want %0d", nm, nstall, t.aw + 1 + t.dw);
        end
        checks++;
        if (stallreq !== 1'b0 || data_req !== 1'b0) begin
            errors++;
            $display("FAIL %s done req/stall: got %b%b want 00", nm, data_req, stallreq);
        end
        for (int h = 0; h < t.mhold; h++) begin
            ext_stall = 6'b011111;
            tick();
            checks++;
            if (stallreq !== 1'b0 || data_req !== 1'b0 || data_sram_rdata !== exp_rdata) begin
                errors++;
                $display("FAIL %s hold h%0d: got req=%b st=%b rd=%h want 0 0 %h",
                         nm, h, data_req, stallreq, data_sram_rdata, exp_rdata);
            end
        end
        ext_stall = '0;
        checks++;
        if (dc_to_mem_bus !== pay) begin
            errors++;
            $display("FAIL %s mem_bus_out: got %h want %h", nm, dc_to_mem_bus, pay);
        end
        checks++;
        if (data_sram_rdata !== exp_rdata) begin
            errors++;
            $display("FAIL %s sram_rdata: got %h want %h", nm, data_sram_rdata, exp_rdata);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ext_stall = '0; addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;
        ex_bus = {$urandom, $urandom, $urandom, $urandom, $urandom, 23'($urandom)};
        tick();
        tick();
        checks++;
        if (data_req !== 1'b0 || stallreq !== 1'b0 || data_wr !== 1'b0 ||
            data_wstrb !== 4'b0 || data_size !== 2'b00 || data_addr !== 32'b0 ||
            data_wdata !== 32'b0 || dc_to_mem_bus !== '0 || data_sram_rdata !== 32'b0 ||
            dc_to_rf_bus !== '0) begin
            errors++;
            $display("FAIL reset outputs: got req=%b st=%b addr=%h rd=%h mem=%h want all 0",
                     data_req, stallreq, data_addr, data_sram_rdata, dc_to_mem_bus);
        end
        ex_bus = '0;
        rst = 1'b0;
        exp_rdata = '0;
        tick();
    endtask

    task automatic test_zero_wait_lw();
        do_op(mk(4, 32'h0000_1000, 4'b1111, 32'hDEAD_BEEF, 0, 0, 0), "zw_lw");
    endtask

    task automatic test_lb_wait();
        do_op(mk(0, 32'h0000_1003, 4'b1000, 32'h0000_00A5, 3, 2, 0), "lb_wait");
    endtask

    task automatic test_sh_store();
        do_op(mk(6, 32'h0000_2002, 4'b1100, 32'hBAD0_BAD0, 0, 1, 0), "sh");
    endtask

    // Load finishes while a later stage stalls, then a store follows directly.
    task automatic test_done_hold();
        do_op(mk(3, 32'h0000_4000, 4'b0011, 32'h1357_9BDF, 1, 1, 3), "hold_lhu");
        do_op(mk(7, 32'h0000_4004, 4'b1111, 32'h0BAD_F00D, 0, 0, 0), "after_hold_sw");
    endtask

    task automatic test_rst_in_data();
        txn_t t;
        t = mk(4, 32'h0000_3000, 4'b1111, 32'h0, 0, 0, 0);
        ex_bus = build(t); ext_stall = '0;
        tick();
        ex_bus = '0;
        addr_ok = 1'b1;
        tick();
        addr_ok = 1'b0;
        checks++;
        if (data_req !== 1'b0 || stallreq !== 1'b1) begin
            errors++;
            $display("FAIL rst_data pre: got req=%b st=%b want 0 1", data_req, stallreq);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_rdata = '0;
        checks++;
        if (data_req !== 1'b0 || stallreq !== 1'b0 || data_addr !== 32'b0 ||
            dc_to_mem_bus !== '0 || data_sram_rdata !== 32'b0 || dc_to_rf_bus !== '0) begin
            errors++;
            $display("FAIL rst_data post: got req=%b st=%b addr=%h rd=%h want all 0",
                     data_req, stallreq, data_addr, data_sram_rdata);
        end
        data_ok = 1'b1; rdata = 32'h1234_5678;
        tick();
        data_ok = 1'b0;
        checks++;
        if (data_req !== 1'b0 || stallreq !== 1'b0 || data_sram_rdata !== 32'b0) begin
            errors++;
            $display("FAIL rst_data stale: got req=%b st=%b rd=%h want 0 0 0",
                     data_req, stallreq, data_sram_rdata);
        end
    endtask

    task automatic test_bubble();
        ex_bus = build(mk(4, 32'h0000_5000, 4'b1111, 32'h0, 0, 0, 0));
        ext_stall = 6'b000111;
        tick();
        checks++;
        if (data_req !== 1'b0 || stallreq !== 1'b0 || dc_to_mem_bus !== '0 ||
            dc_to_rf_bus !== '0) begin
            errors++;
            $display("FAIL bubble: got req=%b st=%b mem=%h want 0 0 0",
                     data_req, stallreq, dc_to_mem_bus);
        end
        ext_stall = '0;
        ex_bus = '0;
        tick();
    endtask

    task automatic test_random_back_to_back();
        txn_t t;
        for (int i = 0; i < 30; i++) begin
            t = mk(int'($urandom_range(0, 8)), $urandom, 4'($urandom), $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 2)));
            do_op(t, $sformatf("rnd%0d_op%0d", i, t.op));
            if ($urandom_range(0, 3) == 0) tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_rdata = '0;
        test_reset();
        test_zero_wait_lw();
        test_lb_wait();
        test_sh_store();
        test_done_hold();
        test_rst_in_data();
        test_bubble();
        test_random_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
